fetch_unit: RTL and testbench

- Instruction-fetch sequencer that sits directly downstream of the 16-bit program counter.
- Reads the PC value and issues one instruction-memory read per instruction.
- Buffers returned instructions in a small queue toward decode.
- Drives the PC's inc/add/sub/offset controls; branch redirects from execute are turned into single-cycle PC add/sub pulses, and stale fetches are flushed.

---
 rtl/fetch_pkg.sv | 29 ++
 rtl/fetch_queue.sv | 76 +++++++
 rtl/fetch_unit.sv | 162 ++++++++++++++++
 tb/tb_fetch_unit.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and defaults for the instruction-fetch slice.
//   fetch_state_t : sequencer states (FETCH / WAIT / DROP)
//   fetch_entry_t : queued instruction {pc, instr}
//   sat_add16     : 16-bit saturating add used by the optional statistics
package fetch_pkg;

  localparam int unsigned AW_DEF     = 16;
  localparam int unsigned IW_DEF     = 16;
  localparam int unsigned QDEPTH_DEF = 2;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    DROP
  } fetch_state_t;

  typedef struct packed {
    logic [AW_DEF-1:0] pc;
    logic [IW_DEF-1:0] instr;
  } fetch_entry_t;

  function automatic logic [15:0] sat_add16(input logic [15:0] a,
                                            input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO of fetch_entry_t with push, pop and flush.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_push/i_data: enqueue one entry
//   i_pop        : dequeue the head (ignored when empty)
//   i_flush      : empty the queue; wins over push and pop
//   o_head       : current head entry
//   o_count      : number of valid entries
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = QDEPTH_DEF
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic                         i_flush,
  input  fetch_entry_t                 i_data,
  output fetch_entry_t                 o_head,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr;
  logic [CW-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign w_full  = (r_count == FULL);
  assign w_empty = (r_count == '0);
  assign w_pop   = i_pop && !w_empty && !i_flush;
  // A push into a full queue is only safe when the head leaves the same cycle.
  assign w_push  = i_push && !i_flush && (!w_full || w_pop);

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= ptr_next(r_wr);
      if (w_pop)  r_rd <= ptr_next(r_rd);
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign o_head  = r_mem[r_rd];
  assign o_count = r_count;

  a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_push && !i_flush && w_full && !w_pop));

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch sequencer between the PC and decode.
// Issues one instruction-memory read per instruction, queues returned words
// toward decode, drives the PC inc/add/sub controls and turns execute
// redirects into single-cycle PC add/sub pulses while flushing stale work.
//   clk, reset              : clock, synchronous active-high reset
//   pc                      : current program counter
//   pc_inc/pc_add/pc_sub    : PC control pulses (mutually exclusive)
//   pc_offset               : offset for pc_add/pc_sub, zero otherwise
//   imem_req/imem_addr      : single-cycle read request
//   imem_rvalid/imem_rdata  : read response
//   br_taken/br_sub/br_offset : redirect from execute
//   ins_valid/ins_data/ins_pc/ins_ready : queue head toward decode
// Optional macro FETCH_STATS_EN adds stat_fetched / stat_flushed counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned AW     = AW_DEF,
  parameter int unsigned IW     = IW_DEF,
  parameter int unsigned QDEPTH = QDEPTH_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] pc,
  output logic          pc_inc,
  output logic          pc_add,
  output logic          pc_sub,
  output logic [AW-1:0] pc_offset,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_rvalid,
  input  logic [IW-1:0] imem_rdata,
  input  logic          br_taken,
  input  logic          br_sub,
  input  logic [AW-1:0] br_offset,
  output logic          ins_valid,
  output logic [IW-1:0] ins_data,
  output logic [AW-1:0] ins_pc,
  input  logic          ins_ready
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0]   stat_fetched,
  output logic [15:0]   stat_flushed
`endif
);

  localparam int unsigned CW = $clog2(QDEPTH + 1);
  localparam logic [CW-1:0] QFULL = CW'(QDEPTH);

  fetch_state_t  r_state;
  logic          r_active;
  logic [AW-1:0] r_req_pc;

  logic          w_en;
  logic          w_redirect;
  logic          w_issue;
  logic          w_accept;
  logic          w_pop;
  logic          w_full;
  logic [CW-1:0] w_count;
  fetch_entry_t  w_push_entry;
  fetch_entry_t  w_head;

  // r_active is low during reset and the first cycle after release, which
  // keeps every output at zero for that cycle.
  assign w_en       = r_active && !reset;
  assign w_redirect = w_en && br_taken;
  assign w_full     = (w_count == QFULL);
  assign w_issue    = w_en && (r_state == FETCH) && !br_taken && !w_full;
  assign w_accept   = w_en && (r_state == WAIT) && imem_rvalid && !br_taken;

  // Controls are combinational from registered state so a redirect reaches
  // the PC in the same cycle it arrives.
  assign pc_inc    = w_accept;
  assign pc_add    = w_redirect && !br_sub;
  assign pc_sub    = w_redirect && br_sub;
  assign pc_offset = w_redirect ? br_offset : '0;
  assign imem_req  = w_issue;
  assign imem_addr = w_issue ? pc : '0;

  assign ins_valid = w_en && (w_count != '0);
  assign ins_pc    = ins_valid ? w_head.pc : '0;
  assign ins_data  = ins_valid ? w_head.instr : '0;
  assign w_pop     = ins_valid && ins_ready && !w_redirect;

  always_comb begin
    w_push_entry       = '0;
    w_push_entry.pc    = r_req_pc;
    w_push_entry.instr = imem_rdata;
  end

  fetch_queue #(
    .DEPTH (QDEPTH)
  ) u_queue (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_push  (w_accept),
    .i_pop   (w_pop),
    .i_flush (w_redirect),
    .i_data  (w_push_entry),
    .o_head  (w_head),
    .o_count (w_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_active <= 1'b0;
      r_state  <= FETCH;
      r_req_pc <= '0;
    end else begin
      r_active <= 1'b1;
      case (r_state)
        FETCH: begin
          if (w_issue) begin
            r_req_pc <= pc;
            r_state  <= WAIT;
          end
        end
        WAIT: begin
          if (w_en && imem_rvalid) begin
            r_state <= FETCH;
          end else if (w_redirect) begin
            r_state <= DROP;
          end
        end
        DROP: begin
          if (w_en && imem_rvalid) begin
            r_state <= FETCH;
          end
        end
        default: r_state <= FETCH;
      endcase
    end
  end

`ifdef FETCH_STATS_EN
  logic [15:0] r_stat_fetched;
  logic [15:0] r_stat_flushed;
  logic        w_discard;
  logic [15:0] w_flush_n;

  // Responses thrown away: collided with a redirect in WAIT, or stale in DROP.
  assign w_discard = w_en && imem_rvalid &&
                     (((r_state == WAIT) && br_taken) || (r_state == DROP));
  assign w_flush_n = (w_redirect ? 16'(w_count) : 16'h0000) + 16'(w_discard);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_fetched <= '0;
      r_stat_flushed <= '0;
    end else begin
      if (w_accept) begin
        r_stat_fetched <= sat_add16(r_stat_fetched, 16'h0001);
      end
      r_stat_flushed <= sat_add16(r_stat_flushed, w_flush_n);
    end
  end

  assign stat_fetched = r_stat_fetched;
  assign stat_flushed = r_stat_flushed;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] data;
  } ent_t;

  localparam int QD = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pc;
  logic        pc_inc, pc_add, pc_sub;
  logic [15:0] pc_offset;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        br_taken, br_sub;
  logic [15:0] br_offset;
  logic        ins_valid;
  logic [15:0] ins_data, ins_pc;
  logic        ins_ready;
`ifdef FETCH_STATS_EN
  logic [15:0] stat_fetched, stat_flushed;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.AW(16), .IW(16), .QDEPTH(QD)) dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .pc_inc      (pc_inc),
    .pc_add      (pc_add),
    .pc_sub      (pc_sub),
    .pc_offset   (pc_offset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .br_taken    (br_taken),
    .br_sub      (br_sub),
    .br_offset   (br_offset),
    .ins_valid   (ins_valid),
    .ins_data    (ins_data),
    .ins_pc      (ins_pc),
    .ins_ready   (ins_ready)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched(stat_fetched),
    .stat_flushed(stat_flushed)
`endif
  );

  int          n_tests;
  int          n_fail;
  // Environment / reference model state
  logic [15:0] tb_pc;
  logic [15:0] rsp_addr;
  logic        m_out;
  logic        m_stale;
  logic        last_rst;
  int          rsp_cnt;
  int          mem_lat;
  int          m_fetched;
  ent_t        exp_q[$];
  logic [15:0] req_log[$];

  function automatic logic [15:0] memf(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5AC3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    logic win, resp, e_add, e_sub, e_inc, e_req, e_valid, pop;
    logic [15:0] e_off;
    ent_t e;
    @(negedge clk);
    win = reset || last_rst;
    last_rst = reset;
    if (win) begin
      chk("rst_imem_req", imem_req, 0);
      chk("rst_imem_addr", imem_addr, 0);
      chk("rst_pc_inc", pc_inc, 0);
      chk("rst_pc_add", pc_add, 0);
      chk("rst_pc_sub", pc_sub, 0);
      chk("rst_pc_offset", pc_offset, 0);
      chk("rst_ins_valid", ins_valid, 0);
      chk("rst_ins_pc", ins_pc, 0);
      chk("rst_ins_data", ins_data, 0);
      if (reset) begin
        exp_q.delete();
        m_out = 1'b0; m_stale = 1'b0; rsp_cnt = 0; m_fetched = 0;
      end
    end else begin
      resp    = imem_rvalid && m_out;
      e_add   = br_taken && !br_sub;
      e_sub   = br_taken && br_sub;
      e_off   = br_taken ? br_offset : 16'h0000;
      e_inc   = resp && !m_stale && !br_taken;
      e_req   = !m_out && (exp_q.size() < QD) && !br_taken;
      e_valid = (exp_q.size() != 0);
      chk("pc_inc", pc_inc, e_inc);
      chk("pc_add", pc_add, e_add);
      chk("pc_sub", pc_sub, e_sub);
      chk("pc_offset", pc_offset, e_off);
      chk("pc_onehot", ($countones({pc_inc, pc_add, pc_sub}) <= 1), 1);
      chk("imem_req", imem_req, e_req);
      if (e_req) chk("imem_addr", imem_addr, tb_pc);
      chk("ins_valid", ins_valid, e_valid);
      if (e_valid) begin
        chk("ins_pc", ins_pc, exp_q[0].pc);
        chk("ins_data", ins_data, exp_q[0].data);
      end
      if (imem_req) req_log.push_back(imem_addr);
      pop = e_valid && ins_ready && !br_taken;
      if (pop) void'(exp_q.pop_front());
      if (br_taken) exp_q.delete();
      if (e_inc) begin
        e.pc = rsp_addr;
        e.data = memf(rsp_addr);
        exp_q.push_back(e);
        m_fetched++;
      end
      if (resp) begin
        m_out = 1'b0; m_stale = 1'b0;
      end else if (br_taken && m_out) begin
        m_stale = 1'b1;
      end
      if (e_req) begin
        m_out = 1'b1; m_stale = 1'b0; rsp_addr = tb_pc; rsp_cnt = mem_lat;
      end
      if (e_add)      tb_pc = tb_pc + e_off;
      else if (e_sub) tb_pc = tb_pc - e_off;
      else if (e_inc) tb_pc = tb_pc + 16'h0001;
    end
    @(posedge clk);
    #1;
    pc = tb_pc;
    imem_rvalid = 1'b0;
    if (rsp_cnt > 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = memf(rsp_addr);
      end
    end
  endtask

  // Let any outstanding read finish, then stop right after the next request.
  task automatic wait_new_req();
    for (int k = 0; k < 20 && m_out; k++) cycle();
    for (int k = 0; k < 20 && !m_out; k++) cycle();
  endtask

  initial begin
    int base;
    n_tests = 0; n_fail = 0;
    reset = 1'b1; tb_pc = 16'h0010; pc = tb_pc;
    br_taken = 1'b0; br_sub = 1'b0; br_offset = '0;
    ins_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    mem_lat = 1; m_out = 1'b0; m_stale = 1'b0; rsp_cnt = 0;
    last_rst = 1'b0; m_fetched = 0;

    // Reset, then straight-line fetch from 0x0010
    repeat (3) cycle();
    reset = 1'b0;
    base = req_log.size();
    repeat (8) cycle();
    chk("sl_req_count", (req_log.size() >= base + 3), 1);
    if (req_log.size() >= base + 3) begin
      chk("sl_addr0", req_log[base],     16'h0010);
      chk("sl_addr1", req_log[base + 1], 16'h0011);
      chk("sl_addr2", req_log[base + 2], 16'h0012);
    end

    // Back-pressure: queue fills to QDEPTH, requests stop, head holds
    ins_ready = 1'b0;
    repeat (10) cycle();
    chk("bp_valid", ins_valid, 1);
    chk("bp_no_req", imem_req, 0);
    base = req_log.size();
    ins_ready = 1'b1;
    repeat (8) cycle();
    chk("bp_resume", (req_log.size() > base), 1);

    // Redirect (subtract) while a read is outstanding; late response dropped
    mem_lat = 3;
    wait_new_req();
    br_taken = 1'b1; br_sub = 1'b1; br_offset = 16'h0004;
    cycle();
    br_taken = 1'b0;
    repeat (8) cycle();

    // Redirect (add) in the same cycle as the response
    mem_lat = 1;
    wait_new_req();
    br_taken = 1'b1; br_sub = 1'b0; br_offset = 16'h0020;
    cycle();
    br_taken = 1'b0;
    chk("sim_queue_empty", ins_valid, 0);
    repeat (6) cycle();

    // PC wrap-around
    reset = 1'b1; tb_pc = 16'hFFFF;
    repeat (2) cycle();
    reset = 1'b0;
    base = req_log.size();
    repeat (6) cycle();
    chk("wrap_req_count", (req_log.size() >= base + 2), 1);
    if (req_log.size() >= base + 2) begin
      chk("wrap_addr0", req_log[base],     16'hFFFF);
      chk("wrap_addr1", req_log[base + 1], 16'h0000);
    end

    // Three fetches, one consumed, two queued, then a redirect flushes them
    reset = 1'b1; tb_pc = 16'h0100; ins_ready = 1'b1;
    repeat (2) cycle();
    reset = 1'b0;
    for (int k = 0; k < 20 && m_fetched < 1; k++) cycle();
    cycle();
    ins_ready = 1'b0;
    for (int k = 0; k < 20 && m_fetched < 3; k++) cycle();
    cycle();
    chk("st_two_queued", ins_valid, 1);
    br_taken = 1'b1; br_sub = 1'b0; br_offset = 16'h0040;
    cycle();
    br_taken = 1'b0;
`ifdef FETCH_STATS_EN
    chk("stat_fetched", stat_fetched, 16'd3);
    chk("stat_flushed", stat_flushed, 16'd2);
`endif
    ins_ready = 1'b1;
    repeat (6) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
